// File: rtl/primcaps_pkg.sv
// Shared defaults for the round-robin multiplier arbiter.
// Holds the default widths and the requester-index width helper.
package primcaps_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int A_W_DEF     = 8;
  localparam int B_W_DEF     = 10;
  localparam int P_W_DEF     = 17;
  localparam int ID_W        = $clog2(NUM_REQ_DEF);

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/primcaps_mul_u.sv
// Combinational unsigned multiplier; operands are zero-extended to a
// common width and the product keeps only its low P_W bits.
module primcaps_mul_u #(
  parameter int A_W = 8,
  parameter int B_W = 10,
  parameter int P_W = 17
) (
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [P_W-1:0] p
);

  localparam int MW = (A_W + B_W > P_W) ? (A_W + B_W) : P_W;

  logic [MW-1:0] a_ext;
  logic [MW-1:0] b_ext;
  logic [MW-1:0] full;

  assign a_ext = MW'(a);
  assign b_ext = MW'(b);
  assign full  = a_ext * b_ext;
  assign p     = full[P_W-1:0];

endmodule

// File: rtl/primcaps_mul_arbiter.sv
// Round-robin arbiter feeding one shared multiplier into a single-entry
// result register with full-throughput valid/ready handshakes.
module primcaps_mul_arbiter
  import primcaps_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int A_W     = A_W_DEF,
  parameter int B_W     = B_W_DEF,
  parameter int P_W     = P_W_DEF,
  localparam int IDW    = id_width(NUM_REQ)
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   res_valid,
  output logic [P_W-1:0]         res_data,
  output logic [IDW-1:0]         res_id,
  input  logic                   res_ready,
  output logic [15:0]            res_count
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           res_valid_q, res_valid_d;
  logic [P_W-1:0] res_data_q, res_data_d;
  logic [IDW-1:0] res_id_q, res_id_d;
  logic [15:0]    res_count_q, res_count_d;

  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic [A_W-1:0] a_sel;
  logic [B_W-1:0] b_sel;
  logic [P_W-1:0] prod;
  logic           can_accept;
  logic           req_xfer;
  logic           res_xfer;
  int             cand;

  // Search upward from the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr_q) + k) % NUM_REQ;
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(cand);
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        a_sel = req_a[i*A_W +: A_W];
        b_sel = req_b[i*B_W +: B_W];
      end
    end
  end

  primcaps_mul_u #(
    .A_W(A_W),
    .B_W(B_W),
    .P_W(P_W)
  ) u_mul (
    .a(a_sel),
    .b(b_sel),
    .p(prod)
  );

  assign can_accept = !res_valid_q || res_ready;
  assign req_ready  = (gnt_found && can_accept && !ap_rst) ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign req_xfer   = |(req_valid & req_ready);
  assign res_xfer   = res_valid_q && res_ready;

  // A request transfer reloads the register even when a result leaves in
  // the same cycle, so back-to-back grants never leave a bubble.
  always_comb begin
    ptr_d       = ptr_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    res_count_d = res_count_q;
    if (req_xfer) begin
      res_valid_d = 1'b1;
      res_data_d  = prod;
      res_id_d    = gnt_idx;
      ptr_d       = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (res_xfer) begin
      res_valid_d = 1'b0;
    end
    if (res_xfer) begin
      res_count_d = res_count_q + 16'd1;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      ptr_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      res_count_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      res_count_q <= res_count_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign res_count = res_count_q;

endmodule

// File: tb/tb_primcaps_mul_arbiter.sv
// Bench for primcaps_mul_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model.
module tb_primcaps_mul_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [39:0] req_b;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic [16:0] res_data;
  logic [1:0]  res_id;
  logic        res_ready;
  logic [15:0] res_count;

  int n_cmp;
  int n_fail;

  // model state
  int m_ptr;
  bit m_pend;
  int m_data;
  int m_id;
  int m_cnt;

  primcaps_mul_arbiter dut (
    .ap_clk   (clk),
    .ap_rst   (rst),
    .req_valid(req_valid),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_ready(req_ready),
    .res_valid(res_valid),
    .res_data (res_data),
    .res_id   (res_id),
    .res_ready(res_ready),
    .res_count(res_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int prod_of(input int g);
    longint a;
    longint b;
    a = longint'((req_a >> (g * 8)) & 32'hFF);
    b = longint'((req_b >> (g * 10)) & 40'h3FF);
    return int'((a * b) % 131072);
  endfunction

  function automatic int exp_grant();
    if (rst) return -1;
    if (m_pend && !res_ready) return -1;
    for (int k = 0; k < 4; k++) begin
      if (req_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    g = exp_grant();
    return (g < 0) ? 4'b0000 : 4'(1 << g);
  endfunction

  task automatic model_clear();
    m_ptr = 0; m_pend = 0; m_data = 0; m_id = 0; m_cnt = 0;
  endtask

  // Predict the state after the coming edge, then move to the next negedge.
  task automatic step();
    int g;
    if (rst) begin
      model_clear();
    end else begin
      g = exp_grant();
      if (m_pend && res_ready) m_cnt = (m_cnt + 1) % 65536;
      if (g >= 0) begin
        m_pend = 1; m_data = prod_of(g); m_id = g; m_ptr = (g + 1) % 4;
      end else if (m_pend && res_ready) begin
        m_pend = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*8 +: 8]   = a[7:0];
    req_b[i*10 +: 10] = b[9:0];
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    req_valid = '0;
    res_ready = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = 4'b1111;
    res_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_cmp++;
    if (res_valid !== 1'b0 || res_data !== 17'd0 || res_id !== 2'd0 || res_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b d=%0d id=%0d cnt=%0d want all 0", res_valid, res_data, res_id, res_count);
    end
    do_reset();
  endtask

  task automatic test_single();
    req_valid = 4'b0001; set_op(0, 3, 5); res_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b want 0001", req_ready); end
    step();
    req_valid = 4'b0000;
    #1;
    n_cmp++;
    if (res_valid !== 1'b1 || res_data !== 17'd15 || res_id !== 2'd0) begin
      n_fail++; $display("FAIL single_result: got v=%b d=%0d id=%0d want 1/15/0", res_valid, res_data, res_id);
    end
    step();
    #1;
    n_cmp++;
    if (res_valid !== 1'b0 || res_count !== 16'd1) begin
      n_fail++; $display("FAIL single_count: got v=%b cnt=%0d want 0/1", res_valid, res_count);
    end
  endtask

  task automatic test_truncation();
    req_valid = 4'b0100; set_op(2, 255, 1023); res_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL trunc_grant: got %b want 0100", req_ready); end
    step();
    req_valid = 4'b0000;
    #1;
    n_cmp++;
    if (res_valid !== 1'b1 || res_data !== 17'd129793 || res_id !== 2'd2) begin
      n_fail++; $display("FAIL trunc_result: got v=%b d=%0d id=%0d want 1/129793/2", res_valid, res_data, res_id);
    end
    step();
  endtask

  task automatic test_fairness();
    int ea [4];
    int eb [4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ea[i] = int'($urandom_range(255));
      eb[i] = int'($urandom_range(1023));
      set_op(i, ea[i], eb[i]);
    end
    req_valid = 4'b1111; res_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      #1;
      n_cmp++;
      if (req_ready !== 4'(1 << (k % 4))) begin
        n_fail++; $display("FAIL fair_grant[%0d]: got %b want %b", k, req_ready, 4'(1 << (k % 4)));
      end
      if (k > 0) begin
        n_cmp++;
        if (res_valid !== 1'b1 || res_id !== 2'((k - 1) % 4) ||
            res_data !== 17'((ea[(k-1)%4] * eb[(k-1)%4]) % 131072)) begin
          n_fail++;
          $display("FAIL fair_result[%0d]: got v=%b id=%0d d=%0d want 1/%0d/%0d", k, res_valid, res_id, res_data,
                   (k - 1) % 4, (ea[(k-1)%4] * eb[(k-1)%4]) % 131072);
        end
      end
      step();
    end
    req_valid = 4'b0000;
    step();
  endtask

  task automatic test_backpressure();
    int held;
    int cnt0;
    set_op(1, int'($urandom_range(255)), int'($urandom_range(1023)));
    held = prod_of(1);
    req_valid = 4'b0010; res_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_grant: got %b want 0010", req_ready); end
    step();
    cnt0 = m_cnt;
    req_valid = 4'b1111; res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_op(1, int'($urandom_range(255)), int'($urandom_range(1023)));
      #1;
      n_cmp++;
      if (req_ready !== 4'b0000 || res_valid !== 1'b1 || res_id !== 2'd1 || res_data !== 17'(held)) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got rdy=%b v=%b id=%0d d=%0d want 0000/1/1/%0d", k, req_ready, res_valid,
                 res_id, res_data, held);
      end
      step();
    end
    res_ready = 1'b1;
    set_op(2, 7, 9);
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_release_grant: got %b want 0100", req_ready); end
    step();
    req_valid = 4'b0000;
    #1;
    n_cmp++;
    if (res_valid !== 1'b1 || res_id !== 2'd2 || res_data !== 17'd63 || res_count !== 16'(cnt0 + 1)) begin
      n_fail++;
      $display("FAIL bp_reload: got v=%b id=%0d d=%0d cnt=%0d want 1/2/63/%0d", res_valid, res_id, res_data,
               res_count, cnt0 + 1);
    end
    step();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      req_valid = 4'($urandom);
      req_a     = $urandom;
      req_b     = {8'($urandom), 32'($urandom)};
      res_ready = ($urandom_range(9) < 7);
      #1;
      n_cmp++;
      if (req_ready !== exp_ready() || res_valid !== m_pend || res_count !== 16'(m_cnt) ||
          (m_pend && (res_data !== 17'(m_data) || res_id !== 2'(m_id)))) begin
        n_fail++;
        $display("FAIL rand[%0d]: got rdy=%b v=%b d=%0d id=%0d cnt=%0d want rdy=%b v=%b d=%0d id=%0d cnt=%0d",
                 k, req_ready, res_valid, res_data, res_id, res_count, exp_ready(), m_pend, m_data, m_id, m_cnt);
      end
      step();
    end
    req_valid = 4'b0000; res_ready = 1'b1;
    step();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    req_valid = 4'b0010; set_op(1, 2, 2); res_ready = 1'b1;
    step();
    req_valid = 4'b0100; set_op(2, 4, 4);
    step();
    req_valid = 4'b0000; res_ready = 1'b0;
    #1;
    n_cmp++;
    if (res_valid !== 1'b1 || res_count !== 16'd1 || res_id !== 2'd2) begin
      n_fail++; $display("FAIL mid_pre: got v=%b cnt=%0d id=%0d want 1/1/2", res_valid, res_count, res_id);
    end
    #1 rst = 1'b1;
    req_valid = 4'b1111;
    model_clear();
    #1;
    n_cmp++;
    if (res_valid !== 1'b0 || res_count !== 16'd0 || res_data !== 17'd0 || req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%b cnt=%0d d=%0d rdy=%b want 0/0/0/0000", res_valid, res_count, res_data,
               req_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b1000; set_op(3, 5, 5); set_op(0, 6, 6); res_ready = 1'b1;
    req_valid = 4'b1001;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_tie: got %b want 0001", req_ready); end
    step();
    req_valid = 4'b0000;
    #1;
    n_cmp++;
    if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== 17'd36) begin
      n_fail++; $display("FAIL mid_after: got v=%b id=%0d d=%0d want 1/0/36", res_valid, res_id, res_data);
    end
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    req_valid = 4'b0001; set_op(0, 1, 1); res_ready = 1'b1;
    for (int k = 0; k < 65536; k++) step();
    #1;
    n_cmp++;
    if (res_count !== 16'hFFFF || res_valid !== 1'b1) begin
      n_fail++; $display("FAIL wrap_ffff: got cnt=%0h v=%b want ffff/1", res_count, res_valid);
    end
    req_valid = 4'b0000;
    step();
    #1;
    n_cmp++;
    if (res_count !== 16'h0000 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL wrap_zero: got cnt=%0h v=%b want 0000/0", res_count, res_valid);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    res_ready = 1'b0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_single();
    test_truncation();
    test_fairness();
    test_backpressure();
    test_random();
    test_reset_midstream();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
